// File: rtl/pwm_deadtime.sv
// Complementary high/low gate driver with programmable dead time, enable gating
// and a sticky fault shutdown. One independent OFF/DEAD/HI/LO machine per channel.
module pwm_deadtime #(
  parameter int N_CHANNELS = 4,
  parameter int WIDTH_DT   = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CHANNELS-1:0]   pwm_in,
  input  logic [WIDTH_DT-1:0]     dead_time,
  input  logic                    enable,
  input  logic                    fault,
  input  logic                    fault_clear,
  output logic [N_CHANNELS-1:0]   pwm_hi,
  output logic [N_CHANNELS-1:0]   pwm_lo,
  output logic                    fault_latched,
  output logic [2*N_CHANNELS-1:0] state_dbg
);

  // state_dbg carries each channel's state in bits [2*i+1:2*i], encoded as below.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } ch_state_t;

  // An incoming fault kills outputs in the same edge it is sampled, not one later.
  logic kill;
  assign kill = !enable || fault_latched || fault;

  // Fault has priority over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_latched <= 1'b0;
    end else if (fault) begin
      fault_latched <= 1'b1;
    end else if (fault_clear) begin
      fault_latched <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    ch_state_t            state;
    logic [WIDTH_DT-1:0]  cnt;
    logic                 hi_q;
    logic                 lo_q;

    // dead_time is captured only on entry to DEAD; cnt <= 1 exits so 0 acts as 1.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= ST_OFF;
        cnt   <= '0;
        hi_q  <= 1'b0;
        lo_q  <= 1'b0;
      end else if (kill) begin
        state <= ST_OFF;
        cnt   <= '0;
        hi_q  <= 1'b0;
        lo_q  <= 1'b0;
      end else begin
        case (state)
          ST_OFF: begin
            state <= ST_DEAD;
            cnt   <= dead_time;
            hi_q  <= 1'b0;
            lo_q  <= 1'b0;
          end
          ST_LO: begin
            if (pwm_in[i]) begin
              state <= ST_DEAD;
              cnt   <= dead_time;
              lo_q  <= 1'b0;
            end
          end
          ST_HI: begin
            if (!pwm_in[i]) begin
              state <= ST_DEAD;
              cnt   <= dead_time;
              hi_q  <= 1'b0;
            end
          end
          ST_DEAD: begin
            if (cnt <= WIDTH_DT'(1)) begin
              if (pwm_in[i]) begin
                state <= ST_HI;
                hi_q  <= 1'b1;
              end else begin
                state <= ST_LO;
                lo_q  <= 1'b1;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= ST_OFF;
            cnt   <= '0;
            hi_q  <= 1'b0;
            lo_q  <= 1'b0;
          end
        endcase
      end
    end

    assign pwm_hi[i]          = hi_q;
    assign pwm_lo[i]          = lo_q;
    assign state_dbg[2*i +: 2] = state;
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: a directed vector table, hand-built timing sequences
// and randomized traffic, all compared against a cycle-level behavioural model.
module tb_pwm_deadtime;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int EW = 2*N + 1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   pwm_in;
  logic [W-1:0]   dead_time;
  logic           enable;
  logic           fault;
  logic           fault_clear;
  logic [N-1:0]   pwm_hi;
  logic [N-1:0]   pwm_lo;
  logic           fault_latched;
  logic [2*N-1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  pwm_deadtime #(.N_CHANNELS(N), .WIDTH_DT(W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pwm_in        (pwm_in),
    .dead_time     (dead_time),
    .enable        (enable),
    .fault         (fault),
    .fault_clear   (fault_clear),
    .pwm_hi        (pwm_hi),
    .pwm_lo        (pwm_lo),
    .fault_latched (fault_latched),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Per channel: m_off = gates forced off, m_gap = dead cycles still to serve,
  // m_lvl = driven side once the gap is over (1 = high, 2 = low).
  int m_off[N];
  int m_gap[N];
  int m_lvl[N];
  bit m_fl;
  logic [EW-1:0] exp_q[$];

  function automatic int gap_len(input logic [W-1:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_off[c] = 1; m_gap[c] = 0; m_lvl[c] = 0;
    end
    m_fl = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] eh, el;
    bit kill;
    kill = !enable || m_fl || fault;
    for (int c = 0; c < N; c++) begin
      if (kill) begin
        m_off[c] = 1; m_gap[c] = 0; m_lvl[c] = 0;
      end else if (m_off[c] != 0) begin
        m_off[c] = 0; m_gap[c] = gap_len(dead_time);
      end else if (m_gap[c] > 0) begin
        m_gap[c]--;
        if (m_gap[c] == 0) m_lvl[c] = pwm_in[c] ? 1 : 2;
      end else if ((m_lvl[c] == 1 && !pwm_in[c]) || (m_lvl[c] == 2 && pwm_in[c])) begin
        m_lvl[c] = 0; m_gap[c] = gap_len(dead_time);
      end
    end
    if (fault) m_fl = 1'b1;
    else if (fault_clear) m_fl = 1'b0;
    for (int c = 0; c < N; c++) begin
      eh[c] = (m_off[c] == 0 && m_gap[c] == 0 && m_lvl[c] == 1);
      el[c] = (m_off[c] == 0 && m_gap[c] == 0 && m_lvl[c] == 2);
    end
    exp_q.push_back({m_fl, eh, el});
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("model", 32'({fault_latched, pwm_hi, pwm_lo}), 32'(e));
    end
    chk("no_overlap", 32'(pwm_hi & pwm_lo), 32'd0);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [N-1:0] p, input logic [W-1:0] d,
                       input logic en, input logic f, input logic fc);
    @(negedge clk);
    pwm_in = p; dead_time = d; enable = en; fault = f; fault_clear = fc;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] pwm;
    logic [W-1:0] dt;
    logic         en, f, fc;
    logic [N-1:0] hi, lo;
    logic         fl;
  } vec_t;

  vec_t vec[27];

  initial begin
    int n;
    logic [N-1:0] p;
    logic [W-1:0] d;

    vec[0]  = '{4'h0, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vec[1]  = '{4'h0, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vec[2]  = '{4'h0, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vec[3]  = '{4'h0, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0};
    vec[4]  = '{4'h1, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0};
    vec[5]  = '{4'h1, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0};
    vec[6]  = '{4'h1, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0};
    vec[7]  = '{4'h1, 8'd3, 1'b1, 1'b0, 1'b0, 4'h1, 4'hE, 1'b0};
    vec[8]  = '{4'h1, 8'd3, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1};
    vec[9]  = '{4'h0, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1};
    vec[10] = '{4'h1, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1};
    vec[11] = '{4'h1, 8'd3, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1};
    vec[12] = '{4'h1, 8'd3, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0};
    vec[13] = '{4'h1, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vec[14] = '{4'h1, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vec[15] = '{4'h1, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vec[16] = '{4'h1, 8'd3, 1'b1, 1'b0, 1'b0, 4'h1, 4'hE, 1'b0};
    vec[17] = '{4'h0, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0};
    vec[18] = '{4'h0, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0};
    vec[19] = '{4'h0, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0};
    vec[20] = '{4'h0, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0};
    vec[21] = '{4'h1, 8'd3, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vec[22] = '{4'h1, 8'd3, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vec[23] = '{4'h1, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vec[24] = '{4'h1, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vec[25] = '{4'h1, 8'd3, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vec[26] = '{4'h1, 8'd3, 1'b1, 1'b0, 1'b0, 4'h1, 4'hE, 1'b0};

    // ---------------- reset ----------------
    reset_n = 1'b0;
    pwm_in = '0; dead_time = 8'd3; enable = 1'b1; fault = 1'b0; fault_clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", 32'(pwm_hi), 32'd0);
    chk("reset_lo", 32'(pwm_lo), 32'd0);
    chk("reset_fl", 32'(fault_latched), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // ---------------- directed table ----------------
    for (int k = 0; k < 27; k++) begin
      drive(vec[k].pwm, vec[k].dt, vec[k].en, vec[k].f, vec[k].fc);
      chk($sformatf("vec%0d_hi", k), 32'(pwm_hi), 32'(vec[k].hi));
      chk($sformatf("vec%0d_lo", k), 32'(pwm_lo), 32'(vec[k].lo));
      chk($sformatf("vec%0d_fl", k), 32'(fault_latched), 32'(vec[k].fl));
    end

    // ---------------- randomized traffic ----------------
    p = '0; d = 8'd3;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) p[b] = ~p[b];
      if ($urandom_range(0, 19) == 0) d = W'($urandom_range(0, 6));
      drive(p, d, ($urandom_range(0, 49) != 0), ($urandom_range(0, 79) == 0),
            ($urandom_range(0, 14) == 0));
    end

    // ---------------- short pulse swallowed ----------------
    repeat (12) drive(4'h0, 8'd4, 1'b1, 1'b0, 1'b1);
    drive(4'h0, 8'd4, 1'b1, 1'b0, 1'b0);
    chk("sp_settled_lo", 32'(pwm_lo), 32'hF);
    n = 0;
    begin
      int hi_seen;
      hi_seen = 0;
      for (int c = 0; c < 10; c++) begin
        drive((c < 2) ? 4'h2 : 4'h0, 8'd4, 1'b1, 1'b0, 1'b0);
        if (!pwm_lo[1]) n++;
        if (pwm_hi[1]) hi_seen++;
      end
      chk("sp_lo_low_cycles", 32'(n), 32'd4);
      chk("sp_hi_never", 32'(hi_seen), 32'd0);
      chk("sp_lo_restored", 32'(pwm_lo[1]), 32'd1);
    end

    // ---------------- zero dead time ----------------
    repeat (4) drive(4'h0, 8'd0, 1'b1, 1'b0, 1'b0);
    n = 0;
    p = '0;
    for (int c = 0; c < 40; c++) begin
      if (c % 5 == 0) p[2] = ~p[2];
      drive(p, 8'd0, 1'b1, 1'b0, 1'b0);
      if (!pwm_hi[2] && !pwm_lo[2]) n++;
    end
    chk("zdt_gap_cycles", 32'(n), 32'd8);

    // ---------------- dead_time change mid-interval ----------------
    repeat (12) drive(4'h0, 8'd6, 1'b1, 1'b0, 1'b0);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      drive(4'h8, (c >= 2) ? 8'd2 : 8'd6, 1'b1, 1'b0, 1'b0);
      if (pwm_hi[3]) break;
      n++;
    end
    chk("dtchg_first_gap", 32'(n), 32'd6);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      drive(4'h0, 8'd2, 1'b1, 1'b0, 1'b0);
      if (pwm_lo[3]) break;
      n++;
    end
    chk("dtchg_second_gap", 32'(n), 32'd2);

    // ---------------- asynchronous reset mid-DEAD ----------------
    drive(4'h8, 8'd5, 1'b1, 1'b0, 1'b0);
    chk("rst_pre_dead", 32'(state_dbg[7:6]), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async_hi", 32'(pwm_hi), 32'd0);
    chk("rst_async_lo", 32'(pwm_lo), 32'd0);
    chk("rst_async_state", 32'(state_dbg), 32'd0);
    model_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
    drive(4'h8, 8'd5, 1'b1, 1'b0, 1'b0);
    chk("rst_reenter_dead", 32'(state_dbg[7:6]), 32'd1);
    repeat (6) drive(4'h8, 8'd5, 1'b1, 1'b0, 1'b0);
    chk("rst_resume_hi", 32'(pwm_hi), 32'h8);

    // ---------------- enable held low ----------------
    p = 4'h1;
    repeat (10) drive(p, 8'd3, 1'b0, 1'b0, 1'b0);
    chk("en_off_outputs", 32'({pwm_hi, pwm_lo}), 32'd0);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      drive(p, 8'd3, 1'b1, 1'b0, 1'b0);
      if (pwm_hi[0]) break;
      n++;
    end
    chk("en_reentry_gap", 32'(n), 32'd3);
    chk("en_no_latch", 32'(fault_latched), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
